qspi_rx_deserializer: RTL and testbench

Receive-side counterpart of the QSPI transmit shifter. Samples the QSPI IO lines on strobes from the serial clock generator, assembles MSB-first bytes at 1, 2 or 4 bits per strobe according to the lane mode, and hands each completed byte to the controller's read path over a valid/ready handshake. A one-byte holding register decouples byte assembly from the consumer. A length counter terminates the transfer.

---
 rtl/qspi_rx_deserializer_pkg.sv | 16 +
 rtl/shift_width_calc.sv | 20 ++
 rtl/qspi_rx_deserializer.sv | 136 +++++++++++++
 tb/tb_qspi_rx_deserializer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_rx_deserializer_pkg.sv
// Shared definitions for the QSPI receive path: lane-mode encodings and
// the receive FSM state type.
package qspi_rx_deserializer_pkg;

    localparam logic [1:0] MODE_ZERO   = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_DUAL   = 2'b10;
    localparam logic [1:0] MODE_QUAD   = 2'b11;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_DONE  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/shift_width_calc.sv
// Bits moved per QSPI strobe for a given lane mode (0 for the no-data mode).
module shift_width_calc
    import qspi_rx_deserializer_pkg::*;
(
    input  logic [1:0] mode,
    output logic [2:0] step
);

    // Decode lane mode into number of IO lines carrying data
    always_comb begin
        step = 3'd0;
        case (mode)
            MODE_SINGLE: step = 3'd1;
            MODE_DUAL:   step = 3'd2;
            MODE_QUAD:   step = 3'd4;
            default:     step = 3'd0;
        endcase
    end

endmodule

// File: rtl/qspi_rx_deserializer.sv
// QSPI receive deserializer: assembles MSB-first bytes from 1/2/4 IO lanes
// on sampling strobes and presents them through a one-byte holding register
// with a valid/ready handshake. A byte counter ends the transfer.
module qspi_rx_deserializer
    import qspi_rx_deserializer_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] rx_len,
    input  logic             sample_en,
    input  logic [3:0]       io_in,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    rx_state_t        state_q, state_d;
    logic [1:0]       mode_q;
    logic [LEN_W-1:0] cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [7:0]       shift_nxt;
    logic [2:0]       step;
    logic [3:0]       bit_sum;
    logic             strobe;
    logic             byte_done;
    logic             last_byte;
    logic             start_ok;
    logic             accept;
    logic             load;

    shift_width_calc u_step (
        .mode (mode_q),
        .step (step)
    );

    // A strobe only counts while shifting; abort takes precedence over it
    assign strobe    = (state_q == RX_SHIFT) && sample_en && !abort;
    assign bit_sum   = {1'b0, bit_cnt_q} + {1'b0, step};
    assign byte_done = strobe && (bit_sum == 4'd8);
    assign last_byte = byte_done && (cnt_q == LEN_W'(1));
    assign start_ok  = start && (rx_len != '0) && (mode != MODE_ZERO);

    assign accept = rx_valid && rx_ready;
    assign load   = byte_done && (!rx_valid || rx_ready);

    assign busy = (state_q == RX_SHIFT);
    assign done = (state_q == RX_DONE);

    // Shift the selected lanes in below the bits already collected
    always_comb begin
        shift_nxt = shift_q;
        case (mode_q)
            MODE_SINGLE: shift_nxt = {shift_q[6:0], io_in[1]};
            MODE_DUAL:   shift_nxt = {shift_q[5:0], io_in[1:0]};
            MODE_QUAD:   shift_nxt = {shift_q[3:0], io_in[3:0]};
            default:     shift_nxt = shift_q;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RX_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; abort overrides everything, DONE lasts one cycle
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = RX_IDLE;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (start_ok)   state_d = RX_SHIFT;
                    else if (start) state_d = RX_DONE;
                end
                RX_SHIFT: begin
                    if (last_byte) state_d = RX_DONE;
                end
                RX_DONE:  state_d = RX_IDLE;
                default:  state_d = RX_IDLE;
            endcase
        end
    end

    // Transfer parameters, partial byte and remaining-byte counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q    <= MODE_ZERO;
            cnt_q     <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
        end else if (abort) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
        end else if ((state_q == RX_IDLE) && start) begin
            mode_q    <= mode;
            cnt_q     <= rx_len;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
        end else if (strobe) begin
            shift_q   <= shift_nxt;
            bit_cnt_q <= bit_sum[2:0];
            if (byte_done) cnt_q <= cnt_q - LEN_W'(1);
        end
    end

    // Holding register: load on completion if free or being drained,
    // otherwise drop the byte and flag overrun until the next transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (load) begin
                rx_data  <= shift_nxt;
                rx_valid <= 1'b1;
            end else if (accept) begin
                rx_valid <= 1'b0;
            end
            if ((state_q == RX_IDLE) && start_ok && !abort) overrun <= 1'b0;
            else if (byte_done && !load)                      overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_qspi_rx_deserializer.sv
// Self-checking bench for qspi_rx_deserializer: table of single-byte
// transfers, hand-written multi-cycle sequences, then randomized traffic
// against a behavioural model.
module tb_qspi_rx_deserializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [15:0] rx_len;
    logic        sample_en;
    logic [3:0]  io_in;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        busy;
    logic        done;
    logic        overrun;

    int nvec = 0;
    int nerr = 0;

    qspi_rx_deserializer #(.LEN_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .rx_len    (rx_len),
        .sample_en (sample_en),
        .io_in     (io_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  m;
        logic [15:0] len;
        logic [7:0]  d;
        logic        exp_valid;
        logic [7:0]  exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nstr(input logic [1:0] m);
        return (m == 2'd1) ? 8 : (m == 2'd2) ? 4 : 2;
    endfunction

    // IO value for the k-th strobe of byte d; unused lines carry noise
    function automatic logic [3:0] lanes_for(input logic [1:0] m, input logic [7:0] d, input int k);
        logic [3:0] io;
        io = 4'($urandom);
        case (m)
            2'd1:    io[1]   = d[7-k];
            2'd2:    io[1:0] = 2'(d >> (6 - 2*k));
            default: io      = 4'(d >> (4 - 4*k));
        endcase
        return io;
    endfunction

    task automatic strobe(input logic [3:0] io);
        sample_en = 1'b1;
        io_in     = io;
        tick();
        sample_en = 1'b0;
        io_in     = 4'($urandom);
    endtask

    // First n strobes of byte d, with occasional idle gaps between them
    task automatic send_partial(input logic [1:0] m, input logic [7:0] d, input int n);
        for (int k = 0; k < n; k++) begin
            if (k != 0 && ($urandom % 3) == 0) tick();
            strobe(lanes_for(m, d, k));
        end
    endtask

    task automatic send_byte(input logic [1:0] m, input logic [7:0] d);
        send_partial(m, d, nstr(m));
    endtask

    task automatic do_start(input logic [1:0] m, input logic [15:0] len);
        start  = 1'b1;
        mode   = m;
        rx_len = len;
        tick();
        start  = 1'b0;
        mode   = 2'($urandom);
        rx_len = 16'($urandom);
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    // Behavioural model state
    int mstate, mmode, mlen, macc, mbits, mvalid, mdata, movr;

    task automatic model_reset();
        mstate = 0; mmode = 0; mlen = 0; macc = 0; mbits = 0;
        mvalid = 0; mdata = 0; movr = 0;
    endtask

    task automatic model_step();
        int nstate, bps, ln, byteval;
        bit comp;
        comp = 1'b0;
        byteval = 0;
        nstate = mstate;
        if (abort) begin
            nstate = 0;
            macc = 0;
            mbits = 0;
        end else if (mstate == 0) begin
            if (start) begin
                mmode = int'(mode);
                mlen  = int'(rx_len);
                if (rx_len == 0 || mode == 2'd0) begin
                    nstate = 2;
                end else begin
                    nstate = 1; macc = 0; mbits = 0; movr = 0;
                end
            end
        end else if (mstate == 1) begin
            if (sample_en) begin
                bps = (mmode == 3) ? 4 : mmode;
                ln  = (mmode == 1) ? int'(io_in[1]) : (mmode == 2) ? int'(io_in[1:0]) : int'(io_in);
                macc  = ((macc * (1 << bps)) + ln) % 256;
                mbits = mbits + bps;
                if (mbits == 8) begin
                    mbits = 0;
                    comp = 1'b1;
                    byteval = macc;
                    mlen = mlen - 1;
                    if (mlen == 0) nstate = 2;
                end
            end
        end else begin
            nstate = 0;
        end
        if (comp) begin
            if (mvalid == 0 || rx_ready) begin
                mdata = byteval;
                mvalid = 1;
            end else begin
                movr = 1;
            end
        end else if (mvalid == 1 && rx_ready) begin
            mvalid = 0;
        end
        mstate = nstate;
    endtask

    vec_t tbl[9];

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; rx_len = '0;
        sample_en = 1'b0; io_in = 4'd0; rx_ready = 1'b0;

        tbl[0] = '{2'd3, 16'd1, 8'hA5, 1'b1, 8'hA5};
        tbl[1] = '{2'd3, 16'd1, 8'h3C, 1'b1, 8'h3C};
        tbl[2] = '{2'd1, 16'd1, 8'hB2, 1'b1, 8'hB2};
        tbl[3] = '{2'd2, 16'd1, 8'h12, 1'b1, 8'h12};
        tbl[4] = '{2'd1, 16'd1, 8'h00, 1'b1, 8'h00};
        tbl[5] = '{2'd3, 16'd1, 8'hFF, 1'b1, 8'hFF};
        tbl[6] = '{2'd2, 16'd1, 8'h81, 1'b1, 8'h81};
        tbl[7] = '{2'd0, 16'd1, 8'h77, 1'b0, 8'h00};
        tbl[8] = '{2'd1, 16'd0, 8'h77, 1'b0, 8'h00};

        tick(); tick();
        check("reset_outputs", {busy, done, overrun, rx_valid, rx_data}, 12'h000);
        reset = 1'b1;
        tick();
        check("idle_after_reset", {busy, done, overrun, rx_valid}, 4'h0);

        // Table of one-byte transfers
        foreach (tbl[i]) begin
            do_start(tbl[i].m, tbl[i].len);
            if (tbl[i].exp_valid) begin
                check($sformatf("t%0d_busy", i), {busy, done}, 2'b10);
                send_partial(tbl[i].m, tbl[i].d, nstr(tbl[i].m) - 1);
                check($sformatf("t%0d_not_yet", i), rx_valid, 1'b0);
                strobe(lanes_for(tbl[i].m, tbl[i].d, nstr(tbl[i].m) - 1));
            end
            check($sformatf("t%0d_valid", i), rx_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) check($sformatf("t%0d_data", i), rx_data, tbl[i].exp_data);
            check($sformatf("t%0d_done", i), {busy, done}, 2'b01);
            tick();
            check($sformatf("t%0d_done_once", i), {busy, done, rx_valid}, {2'b00, tbl[i].exp_valid});
            drain();
            check($sformatf("t%0d_drained", i), rx_valid, 1'b0);
        end

        // QUAD, two bytes, consumer always ready
        rx_ready = 1'b1;
        do_start(2'd3, 16'd2);
        strobe(4'hA); strobe(4'h5);
        check("q2_byte1", {rx_valid, rx_data, done}, {1'b1, 8'hA5, 1'b0});
        strobe(4'h3);
        check("q2_consumed", rx_valid, 1'b0);
        strobe(4'hC);
        check("q2_byte2", {rx_valid, rx_data, done, overrun}, {1'b1, 8'h3C, 1'b1, 1'b0});
        tick();
        check("q2_idle", {busy, done, rx_valid}, 3'b000);
        rx_ready = 1'b0;

        // DUAL, three bytes, consumer never ready -> overrun
        do_start(2'd2, 16'd3);
        send_byte(2'd2, 8'h12);
        check("ovr_byte1", {rx_valid, rx_data, overrun}, {1'b1, 8'h12, 1'b0});
        send_byte(2'd2, 8'h34);
        check("ovr_byte2", {rx_valid, rx_data, overrun}, {1'b1, 8'h12, 1'b1});
        send_byte(2'd2, 8'h56);
        check("ovr_byte3", {rx_valid, rx_data, overrun, done}, {1'b1, 8'h12, 1'b1, 1'b1});
        tick();
        check("ovr_sticky", {overrun, done}, 2'b10);
        drain();

        // Accept of old byte and load of new byte in the same cycle
        do_start(2'd1, 16'd2);
        send_byte(2'd1, 8'h5A);
        send_partial(2'd1, 8'hC3, 7);
        check("sim_old", {rx_valid, rx_data, overrun}, {1'b1, 8'h5A, 1'b0});
        rx_ready = 1'b1;
        strobe(lanes_for(2'd1, 8'hC3, 7));
        rx_ready = 1'b0;
        check("sim_new", {rx_valid, rx_data, overrun, done}, {1'b1, 8'hC3, 1'b0, 1'b1});
        tick();
        drain();

        // Abort partway through a SINGLE byte, then a clean QUAD byte
        do_start(2'd1, 16'd1);
        send_partial(2'd1, 8'hFF, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {busy, done, rx_valid}, 3'b000);
        tick();
        check("abort_no_done", {busy, done, rx_valid}, 3'b000);
        do_start(2'd3, 16'd1);
        send_byte(2'd3, 8'hF0);
        check("after_abort", {rx_valid, rx_data, done}, {1'b1, 8'hF0, 1'b1});
        tick();
        drain();

        // Asynchronous reset in the middle of a transfer
        do_start(2'd3, 16'd2);
        send_byte(2'd3, 8'h9E);
        strobe(4'h7);
        #2 reset = 1'b0;
        #1 check("async_reset", {busy, done, overrun, rx_valid, rx_data}, 12'h000);
        tick();
        reset = 1'b1;
        tick();
        do_start(2'd1, 16'd1);
        send_byte(2'd1, 8'h6D);
        check("post_reset", {rx_valid, rx_data, done}, {1'b1, 8'h6D, 1'b1});
        tick();
        drain();

        // Randomized traffic against the model, from a fresh reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        tick();
        for (int c = 0; c < 3000; c++) begin
            check("rand", {busy, done, overrun, rx_valid, rx_data},
                  {(mstate == 1), (mstate == 2), (movr != 0), (mvalid != 0), 8'(mdata)});
            start     = (($urandom % 8) == 0);
            abort     = (($urandom % 40) == 0);
            sample_en = 1'($urandom);
            io_in     = 4'($urandom);
            rx_ready  = (($urandom % 3) != 0);
            mode      = 2'($urandom);
            rx_len    = 16'($urandom_range(0, 3));
            model_step();
            tick();
        end
        start = 1'b0; abort = 1'b0; sample_en = 1'b0; rx_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
